// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access unit.
// Holds the FSM state encoding and the default watchdog limit.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_access_if.sv
// Core-side request/response and bus-side signals of the access unit.
// master = the unit itself, slave = the core plus memory it talks to.
interface mem_access_if;

  logic        start;
  logic        is_store;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;
  logic [15:0] next_addr;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (
    input  start, is_store, addr, wdata,
    input  mem_ack, mem_rdata,
    output busy, done, rdata, next_addr, err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output start, is_store, addr, wdata,
    output mem_ack, mem_rdata,
    input  busy, done, rdata, next_addr, err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mau_watchdog.sv
// ACCESS-cycle watchdog: counts un-acked bus cycles since the last clear.
// o_expired fires in the cycle whose count would reach i_limit.
module mau_watchdog (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_enable,
  input  logic [15:0] i_limit,
  output logic        o_expired
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 16'd0;
    end else if (i_clear) begin
      r_cnt <= 16'd0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_expired = i_enable &&
    (({1'b0, r_cnt} + 17'd1) == {1'b0, i_limit});

endmodule

// File: rtl/mem_access_unit.sv
// Single-beat load/store bus sequencer with address post-increment.
// Define MEM_ACCESS_TIMEOUT_EN to build in the ACCESS watchdog.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic          clk,
  input  logic          reset,
  mem_access_if.master  bus
);

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_ack;
  logic        w_expired;
  logic        r_is_store;
  logic [15:0] r_addr;
  logic [15:0] r_next_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_ack    = (r_state == ACCESS) && bus.mem_ack;

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic        r_err;
  logic        w_wd_en;
  logic [15:0] w_limit;

  assign w_wd_en = (r_state == ACCESS) && !bus.mem_ack;
  assign w_limit = 16'(TIMEOUT_CYCLES);

  mau_watchdog u_wdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_accept),
    .i_enable  (w_wd_en),
    .i_limit   (w_limit),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_expired) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  logic w_unused_limit;

  assign w_unused_limit = ^TIMEOUT_CYCLES;
  assign w_expired      = 1'b0;
  assign bus.err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = ACCESS;
      ACCESS:  if (bus.mem_ack || w_expired) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_store  <= 1'b0;
      r_addr      <= 16'h0000;
      r_next_addr <= 16'h0000;
      r_wdata     <= 8'h00;
      r_rdata     <= 8'h00;
    end else begin
      if (w_accept) begin
        r_is_store  <= bus.is_store;
        r_addr      <= bus.addr;
        r_next_addr <= bus.addr + 16'd1;
        r_wdata     <= bus.wdata;
      end
      if (w_ack && !r_is_store) begin
        r_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.mem_req   = (r_state == ACCESS);
  assign bus.mem_we    = (r_state == ACCESS) && r_is_store;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.rdata     = r_rdata;
  assign bus.next_addr = r_next_addr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit.
// Timeout vectors run only when MEM_ACCESS_TIMEOUT_EN is defined.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int ST_REQ = 3;
`else
  localparam int ST_REQ = 5;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  mem_access_if bus ();

  mem_access_unit #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic st, input logic [15:0] a,
                    input logic [7:0] d);
    bus.start    = 1'b1;
    bus.is_store = st;
    bus.addr     = a;
    bus.wdata    = d;
    cyc();
    bus.start    = 1'b0;
  endtask

  int  rq;
  int  dn;
  int  rise;
  logic prev;
  logic ev;

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.is_store  = 1'b0;
    bus.addr      = 16'h0;
    bus.wdata     = 8'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h0;
    #2;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_req", 32'(bus.mem_req), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_next", 32'(bus.next_addr), 0);
    chk("rst_maddr", 32'(bus.mem_addr), 0);
    chk("rst_mwdata", 32'(bus.mem_wdata), 0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

    // load, ack right away
    go(1'b0, 16'h1234, 8'h00);
    chk("ld_req", 32'(bus.mem_req), 1);
    chk("ld_we", 32'(bus.mem_we), 0);
    chk("ld_maddr", 32'(bus.mem_addr), 32'h1234);
    chk("ld_busy", 32'(bus.busy), 1);
    chk("ld_done_early", 32'(bus.done), 0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'hA5;
    cyc();
    bus.mem_ack   = 1'b0;
    chk("ld_done", 32'(bus.done), 1);
    chk("ld_req_fall", 32'(bus.mem_req), 0);
    chk("ld_rdata", 32'(bus.rdata), 32'hA5);
    chk("ld_err", 32'(bus.err), 0);
    chk("ld_next", 32'(bus.next_addr), 32'h1235);
    cyc();
    chk("ld_done_1cyc", 32'(bus.done), 0);
    chk("ld_idle", 32'(bus.busy), 0);

    // store, acked after ST_REQ request cycles
    go(1'b1, 16'h00FF, 8'h3C);
    chk("st_we", 32'(bus.mem_we), 1);
    chk("st_wdata", 32'(bus.mem_wdata), 32'h3C);
    chk("st_maddr", 32'(bus.mem_addr), 32'h00FF);
    rq = 0;
    dn = 0;
    for (int i = 0; i < ST_REQ + 4; i++) begin
      if (bus.mem_req) rq++;
      if (bus.done) dn++;
      bus.mem_ack   = (i == ST_REQ - 1);
      bus.mem_rdata = 8'h11;
      cyc();
    end
    bus.mem_ack = 1'b0;
    chk("st_req_cycles", 32'(rq), 32'(ST_REQ));
    chk("st_done_cnt", 32'(dn), 1);
    chk("st_rdata_kept", 32'(bus.rdata), 32'hA5);
    chk("st_err", 32'(bus.err), 0);
    chk("st_next", 32'(bus.next_addr), 32'h0100);

    // wrap + start while busy
    go(1'b0, 16'hFFFF, 8'h00);
    rise = 1;
    dn   = 0;
    prev = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.mem_req && !prev) rise++;
      prev = bus.mem_req;
      if (bus.done) dn++;
      bus.start     = (i < 3);
      bus.addr      = 16'h5555;
      bus.mem_ack   = (i == 1);
      bus.mem_rdata = 8'h77;
      cyc();
    end
    bus.start   = 1'b0;
    bus.mem_ack = 1'b0;
    chk("wrap_next", 32'(bus.next_addr), 32'h0000);
    chk("wrap_txns", 32'(rise), 1);
    chk("wrap_done", 32'(dn), 1);
    chk("wrap_maddr", 32'(bus.mem_addr), 32'hFFFF);
    chk("wrap_rdata", 32'(bus.rdata), 32'h77);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // never acked: watchdog aborts after 4 cycles
    go(1'b0, 16'h0042, 8'h00);
    rq = 0;
    dn = 0;
    ev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.mem_req) rq++;
      if (bus.done) begin
        dn++;
        ev = bus.err;
      end
      cyc();
    end
    chk("to_req_cycles", 32'(rq), 4);
    chk("to_done", 32'(dn), 1);
    chk("to_err", 32'(ev), 1);
    chk("to_rdata_kept", 32'(bus.rdata), 32'h77);

    // ack in the 4th cycle beats the watchdog
    go(1'b0, 16'h0043, 8'h00);
    chk("to2_err_clr", 32'(bus.err), 0);
    rq = 0;
    dn = 0;
    ev = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.mem_req) rq++;
      if (bus.done) begin
        dn++;
        ev = bus.err;
      end
      bus.mem_ack   = (i == 3);
      bus.mem_rdata = 8'h99;
      cyc();
    end
    bus.mem_ack = 1'b0;
    chk("to2_req_cycles", 32'(rq), 4);
    chk("to2_done", 32'(dn), 1);
    chk("to2_err", 32'(ev), 0);
    chk("to2_rdata", 32'(bus.rdata), 32'h99);
`endif

    // async reset in the middle of ACCESS
    go(1'b0, 16'h2000, 8'h00);
    chk("rs_req_before", 32'(bus.mem_req), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rs_req_now", 32'(bus.mem_req), 0);
    chk("rs_busy_now", 32'(bus.busy), 0);
    chk("rs_next", 32'(bus.next_addr), 0);
    cyc();
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done) dn++;
      cyc();
    end
    chk("rs_no_done", 32'(dn), 0);
    go(1'b0, 16'h0010, 8'h00);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'h5A;
    cyc();
    bus.mem_ack   = 1'b0;
    chk("rs_ld_done", 32'(bus.done), 1);
    chk("rs_ld_rdata", 32'(bus.rdata), 32'h5A);
    chk("rs_ld_next", 32'(bus.next_addr), 32'h0011);
    cyc();

    // stray ack while idle
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'hEE;
    dn = 0;
    cyc();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.done || bus.busy) dn++;
      cyc();
    end
    chk("stray_done", 32'(dn), 0);
    chk("stray_rdata", 32'(bus.rdata), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
